// File: rtl/csr_counter_read_pkg.sv
// Shared constants for the unprivileged counter-CSR read responder:
// CSR addresses, privilege encodings and the response FSM state type.
package csr_counter_read_pkg;

    localparam logic [11:0] CSR_CYCLE      = 12'hC00;
    localparam logic [11:0] CSR_TIME       = 12'hC01;
    localparam logic [11:0] CSR_INSTRET    = 12'hC02;
    localparam logic [11:0] CSR_HPM_LO     = 12'hC03;
    localparam logic [11:0] CSR_HPM_HI     = 12'hC1F;
    localparam logic [11:0] CSR_MCOUNTEREN = 12'h306;
    localparam logic [11:0] CSR_SCOUNTEREN = 12'h106;

    localparam logic [1:0] PRIV_M_DEF = 2'b11;
    localparam logic [1:0] PRIV_S_DEF = 2'b01;
    localparam logic [1:0] PRIV_U_DEF = 2'b00;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

endpackage

// File: rtl/csr_counter_read_perm_check.sv
// Combinational legality decode for a counter-CSR access: address range,
// write attempts and the mcounteren/scounteren permission chain.
module counter_perm_check
    import csr_counter_read_pkg::*;
#(
    parameter logic [1:0] PRIV_M = PRIV_M_DEF,
    parameter logic [1:0] PRIV_S = PRIV_S_DEF
) (
    input  logic [11:0] req_addr,
    input  logic        req_write,
    input  logic [1:0]  priv,
    input  logic [31:0] mcounteren,
    input  logic [31:0] scounteren,
    output logic        illegal
);

    logic       is_m, is_s, is_u;
    logic       in_ctr_range;
    logic [4:0] idx;

    // Anything that is neither M nor S (including reserved 2'b10) acts as U.
    assign is_m = (priv == PRIV_M);
    assign is_s = (priv == PRIV_S);
    assign is_u = !is_m && !is_s;

    assign in_ctr_range = (req_addr[11:5] == CSR_CYCLE[11:5]);
    assign idx          = req_addr[4:0];

    always_comb begin
        illegal = 1'b1;
        if (in_ctr_range) begin
            illegal = req_write
                   || (is_s && !mcounteren[idx])
                   || (is_u && !(mcounteren[idx] && scounteren[idx]));
        end else if (req_addr == CSR_MCOUNTEREN) begin
            illegal = !is_m;
        end else if (req_addr == CSR_SCOUNTEREN) begin
            illegal = is_u;
        end
    end

endmodule

// File: rtl/csr_counter_read.sv
// Counter-CSR read responder: owns mcounteren/scounteren, snapshots the live
// counters on acceptance and holds a registered response until consumed.
module csr_counter_read
    import csr_counter_read_pkg::*;
#(
    parameter logic [1:0] PRIV_M = PRIV_M_DEF,
    parameter logic [1:0] PRIV_S = PRIV_S_DEF,
    parameter logic [1:0] PRIV_U = PRIV_U_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [11:0] req_addr,
    input  logic        req_write,
    input  logic [63:0] req_wdata,
    input  logic [1:0]  priv,
    input  logic [63:0] mcycle,
    input  logic [63:0] minstret,
    input  logic [63:0] mtime,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_data,
    output logic        rsp_illegal,
    output logic [63:0] mcounteren_o,
    output logic [63:0] scounteren_o
);

    state_t      state, state_nxt;
    logic        accept;
    logic        illegal;
    logic [63:0] rd_val;
    logic [31:0] mcounteren, scounteren;
    logic        unused_ok;

    // Only the low 32 bits of a counteren write are architecturally kept;
    // PRIV_U documents the encoding, everything non-M/S decodes as U anyway.
    assign unused_ok = ^{req_wdata[63:32], PRIV_U};

    counter_perm_check #(
        .PRIV_M (PRIV_M),
        .PRIV_S (PRIV_S)
    ) u_perm (
        .req_addr   (req_addr),
        .req_write  (req_write),
        .priv       (priv),
        .mcounteren (mcounteren),
        .scounteren (scounteren),
        .illegal    (illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                accept    = req_valid;
                if (req_valid) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_val = 64'd0;
        case (req_addr)
            CSR_CYCLE:      rd_val = mcycle;
            CSR_TIME:       rd_val = mtime;
            CSR_INSTRET:    rd_val = minstret;
            CSR_MCOUNTEREN: rd_val = {32'd0, mcounteren};
            CSR_SCOUNTEREN: rd_val = {32'd0, scounteren};
            default:        rd_val = 64'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid   <= 1'b0;
            rsp_data    <= 64'd0;
            rsp_illegal <= 1'b0;
            mcounteren  <= 32'd0;
            scounteren  <= 32'd0;
        end else if (accept) begin
            rsp_valid   <= 1'b1;
            rsp_illegal <= illegal;
            rsp_data    <= illegal ? 64'd0 : rd_val;
            if (!illegal && req_write && req_addr == CSR_MCOUNTEREN)
                mcounteren <= req_wdata[31:0];
            if (!illegal && req_write && req_addr == CSR_SCOUNTEREN)
                scounteren <= req_wdata[31:0];
        end else if (state == ST_RESP && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    assign mcounteren_o = {32'd0, mcounteren};
    assign scounteren_o = {32'd0, scounteren};

endmodule

// File: tb/tb_csr_counter_read.sv
// Directed vector bench for csr_counter_read: a table of single requests with
// hand-computed responses plus hold/backpressure and reset-in-RESP sequences.
module tb_csr_counter_read;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [11:0] req_addr;
    logic        req_write;
    logic [63:0] req_wdata;
    logic [1:0]  priv;
    logic [63:0] mcycle, minstret, mtime;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;
    logic        rsp_illegal;
    logic [63:0] mcounteren_o, scounteren_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    csr_counter_read dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_write    (req_write),
        .req_wdata    (req_wdata),
        .priv         (priv),
        .mcycle       (mcycle),
        .minstret     (minstret),
        .mtime        (mtime),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_illegal  (rsp_illegal),
        .mcounteren_o (mcounteren_o),
        .scounteren_o (scounteren_o)
    );

    typedef struct {
        logic [1:0]  priv;
        logic [11:0] addr;
        logic        write;
        logic [63:0] wdata;
        logic [63:0] cyc;
        logic [63:0] ins;
        logic [63:0] tim;
        logic [63:0] exp_data;
        logic        exp_ill;
        logic [63:0] exp_mcen;
        logic [63:0] exp_scen;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] p, input logic [11:0] a, input logic w,
                       input logic [63:0] wd, input logic [63:0] c, input logic [63:0] i,
                       input logic [63:0] t, input logic [63:0] ed, input logic ei,
                       input logic [63:0] em, input logic [63:0] es);
        vec_t v;
        v.priv = p; v.addr = a; v.write = w; v.wdata = wd;
        v.cyc = c; v.ins = i; v.tim = t;
        v.exp_data = ed; v.exp_ill = ei; v.exp_mcen = em; v.exp_scen = es;
        vecs.push_back(v);
    endtask

    // Drive a request at a negedge; response is checked at the following negedge.
    task automatic issue(input logic [1:0] p, input logic [11:0] a, input logic w,
                         input logic [63:0] wd);
        int waited = 0;
        while (!req_ready && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            total++; bad++;
            $display("FAIL ready_timeout: req_ready stuck at 0 expected 1");
        end
        priv = p; req_addr = a; req_write = w; req_wdata = wd; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_valid_drop", {63'd0, rsp_valid}, 64'd0);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_wdata = '0;
        priv = 2'b00; mcycle = '0; minstret = '0; mtime = '0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check("reset_req_ready",   {63'd0, req_ready},   64'd1);
        check("reset_rsp_valid",   {63'd0, rsp_valid},   64'd0);
        check("reset_rsp_data",    rsp_data,             64'd0);
        check("reset_rsp_illegal", {63'd0, rsp_illegal}, 64'd0);
        check("reset_mcen",        mcounteren_o,         64'd0);
        check("reset_scen",        scounteren_o,         64'd0);

        //   priv   addr     w  wdata                   mcycle   minstret  mtime   exp_data exp_ill mcen scen
        add(2'b00, 12'hC00, 0, 64'h0,                   64'd100, 64'h0,    64'h0,  64'h0,    1,     0,   0);
        add(2'b11, 12'h306, 1, 64'h7,                   64'h0,   64'h0,    64'h0,  64'h0,    0,     7,   0);
        add(2'b01, 12'h106, 1, 64'h5,                   64'h0,   64'h0,    64'h0,  64'h0,    0,     7,   5);
        add(2'b00, 12'hC02, 0, 64'h0,                   64'h0,   64'h1234, 64'h0,  64'h1234, 0,     7,   5);
        add(2'b00, 12'hC01, 0, 64'h0,                   64'h0,   64'h0,    64'h55, 64'h0,    1,     7,   5);
        add(2'b01, 12'hC01, 0, 64'h0,                   64'h0,   64'h0,    64'h55, 64'h55,   0,     7,   5);
        add(2'b11, 12'hC03, 0, 64'h0,                   64'h9,   64'h9,    64'h9,  64'h0,    0,     7,   5);
        add(2'b11, 12'hC00, 1, 64'hAB,                  64'h33,  64'h0,    64'h0,  64'h0,    1,     7,   5);
        add(2'b11, 12'h306, 0, 64'h0,                   64'h0,   64'h0,    64'h0,  64'h7,    0,     7,   5);
        add(2'b11, 12'h306, 1, 64'hFFFF_FFFF_0000_0003, 64'h0,   64'h0,    64'h0,  64'h7,    0,     3,   5);
        add(2'b01, 12'h306, 0, 64'h0,                   64'h0,   64'h0,    64'h0,  64'h0,    1,     3,   5);
        add(2'b00, 12'h106, 0, 64'h0,                   64'h0,   64'h0,    64'h0,  64'h0,    1,     3,   5);
        add(2'b01, 12'h106, 0, 64'h0,                   64'h0,   64'h0,    64'h0,  64'h5,    0,     3,   5);
        add(2'b10, 12'hC00, 0, 64'h0,                   64'h77,  64'h0,    64'h0,  64'h77,   0,     3,   5);
        add(2'b10, 12'hC02, 0, 64'h0,                   64'h0,   64'h99,   64'h0,  64'h0,    1,     3,   5);
        add(2'b11, 12'h300, 0, 64'h0,                   64'h0,   64'h0,    64'h0,  64'h0,    1,     3,   5);
        add(2'b11, 12'hC1F, 0, 64'h0,                   64'h0,   64'h0,    64'h0,  64'h0,    0,     3,   5);
        add(2'b01, 12'hC1F, 0, 64'h0,                   64'h0,   64'h0,    64'h0,  64'h0,    1,     3,   5);
        add(2'b11, 12'h106, 1, 64'h1,                   64'h0,   64'h0,    64'h0,  64'h5,    0,     3,   1);

        foreach (vecs[k]) begin
            mcycle = vecs[k].cyc; minstret = vecs[k].ins; mtime = vecs[k].tim;
            issue(vecs[k].priv, vecs[k].addr, vecs[k].write, vecs[k].wdata);
            check($sformatf("v%0d_rsp_valid", k),   {63'd0, rsp_valid},   64'd1);
            check($sformatf("v%0d_req_ready", k),   {63'd0, req_ready},   64'd0);
            check($sformatf("v%0d_rsp_data", k),    rsp_data,             vecs[k].exp_data);
            check($sformatf("v%0d_rsp_illegal", k), {63'd0, rsp_illegal}, {63'd0, vecs[k].exp_ill});
            check($sformatf("v%0d_mcen", k),        mcounteren_o,         vecs[k].exp_mcen);
            check($sformatf("v%0d_scen", k),        scounteren_o,         vecs[k].exp_scen);
            consume();
        end

        // Backpressure: snapshot must hold and a pending write must be ignored.
        mcycle = 64'd1000;
        issue(2'b11, 12'hC00, 1'b0, 64'h0);
        req_valid = 1'b1; req_addr = 12'h306; req_write = 1'b1; req_wdata = 64'hFF;
        for (int c = 0; c < 5; c++) begin
            mcycle = mcycle + 64'd1;
            @(negedge clk);
            check("hold_rsp_data",  rsp_data,            64'd1000);
            check("hold_req_ready", {63'd0, req_ready},  64'd0);
            check("hold_rsp_valid", {63'd0, rsp_valid},  64'd1);
            check("hold_mcen",      mcounteren_o,        64'd3);
        end
        req_valid = 1'b0;
        consume();
        check("hold_mcen_after", mcounteren_o, 64'd3);

        // Reset while a response is pending.
        issue(2'b11, 12'hC00, 1'b0, 64'h0);
        check("rstresp_valid_pre", {63'd0, rsp_valid}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstresp_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rstresp_req_ready", {63'd0, req_ready}, 64'd1);
        check("rstresp_mcen",      mcounteren_o,       64'd0);
        check("rstresp_scen",      scounteren_o,       64'd0);

        // Counteren cleared: S counter read now illegal.
        mtime = 64'h55;
        issue(2'b01, 12'hC01, 1'b0, 64'h0);
        check("post_rst_illegal", {63'd0, rsp_illegal}, 64'd1);
        check("post_rst_data",    rsp_data,             64'd0);
        consume();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/csr_counter_read.md
# csr_counter_read

Unprivileged counter-CSR read responder. It serves `cycle`, `time`, `instret` and `hpmcounter3..31` reads from lower-privilege code. Access is gated by the `mcounteren`/`scounteren` enable registers, which this block owns. It sits beside the machine counter block: it consumes the live `mcycle`/`minstret` values and the platform `mtime` value. Results go back to the CSR unit through a registered request/response handshake, with an illegal-instruction flag.

## Interface
Parameters:
- `PRIV_M`, default 2'b11: machine privilege encoding.
- `PRIV_S`, default 2'b01: supervisor privilege encoding.
- `PRIV_U`, default 2'b00: user privilege encoding.

Ports (reset `rst`, synchronous, active-high; clock `clk`):
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `req_valid`  in  1  CSR access request
- `req_ready`  out  1  block can accept a request
- `req_addr`  in  12  CSR address
- `req_write`  in  1  access writes the CSR (CSRRW/S/C with a nonzero write effect)
- `req_wdata`  in  64  final value to write (CSR unit has already applied set/clear)
- `priv`  in  2  current privilege level
- `mcycle`  in  64  live cycle count
- `minstret`  in  64  live retired-instruction count
- `mtime`  in  64  platform timer
- `rsp_valid`  out  1  response available
- `rsp_ready`  in  1  CSR unit consumes the response
- `rsp_data`  out  64  read value (old value on writes)
- `rsp_illegal`  out  1  access raises illegal-instruction
- `mcounteren_o`  out  64  {32'b0, mcounteren}
- `scounteren_o`  out  64  {32'b0, scounteren}

## Operation
- Two-state FSM.
  - IDLE: `req_ready`=1. On `req_valid`, capture the result and go to RESP.
  - RESP: `req_ready`=0 and `rsp_valid`=1. On `rsp_ready`, go to IDLE.
- Address map:
  - 0xC00 returns `mcycle`; 0xC01 returns `mtime`; 0xC02 returns `minstret`.
  - 0xC03–0xC1F return 0.
  - 0x306 is `mcounteren`; 0x106 is `scounteren`.
- Counter index i = `req_addr[4:0]` for the 0xC00–0xC1F range.
- Counter read permission:
  - M: always allowed.
  - S: allowed iff `mcounteren[i]`.
  - U: allowed iff `mcounteren[i] & scounteren[i]`.
- Illegal cases, each giving `rsp_illegal`=1 and `rsp_data`=0:
  - any write to 0xC00–0xC1F;
  - a counter read that fails the permission check;
  - access to 0x306 with `priv`≠M;
  - access to 0x106 with `priv`=U;
  - any other address.
- Legal write to 0x306/0x106: the register takes `req_wdata[31:0]` at the acceptance edge. `rsp_data` returns the pre-write value, zero-extended.
- Illegal requests never modify state.
- Counter values are snapshotted at the acceptance edge. Later counter motion does not change a held `rsp_data`.
- Reserved privilege encoding 2'b10 is treated as U.

## Timing
- Reset values:
  - state IDLE, `req_ready`=1;
  - `rsp_valid`=0, `rsp_data`=0, `rsp_illegal`=0;
  - `mcounteren`=0, `scounteren`=0.
- Latency: request accepted at edge N gives `rsp_valid`=1 from edge N onward, i.e. visible in cycle N+1.
- `rsp_data` and `rsp_illegal` are stable while `rsp_valid`=1 and `rsp_ready`=0.
- Throughput: at most one request per 2 cycles. There is no accept in the same cycle as `rsp_ready`.
- `req_valid` while `req_ready`=0 is ignored. The requester holds it.
- A counteren write is visible to permission checks of the next accepted request.
- `rst` during RESP: the response is dropped, `rsp_valid`=0 next cycle, and the counteren registers are cleared.
- All outputs are registered except `req_ready`, which is decoded from the state register.

## Structure
- Shared package holds:
  - CSR address constants (`CSR_CYCLE`=12'hC00, `CSR_TIME`, `CSR_INSTRET`, `CSR_HPM_LO`=12'hC03, `CSR_HPM_HI`=12'hC1F, `CSR_MCOUNTEREN`=12'h306, `CSR_SCOUNTEREN`=12'h106);
  - privilege encodings;
  - FSM state encoding.
- One natural sub-module, `counter_perm_check`: combinational permission/illegal decode from `req_addr`, `req_write`, `priv`, `mcounteren`, `scounteren`.
- The top holds the FSM, the counteren registers and the response registers.

## Test plan
- After reset: U reads 0xC00 with `mcycle`=100 → `rsp_valid` next cycle, `rsp_illegal`=1, `rsp_data`=0.
- M writes 0x306 with 0x7, then S writes 0x106 with 0x5. U reads 0xC02 with `minstret`=0x1234 → `rsp_data`=0x1234, `rsp_illegal`=0. U reads 0xC01 → illegal. S reads 0xC01 with `mtime`=0x55 → `rsp_data`=0x55.
- M reads 0xC03 → `rsp_data`=0, not illegal. M writes 0xC00 → illegal, and a following M read of 0x306 is unchanged.
- M writes 0x306 with 0xFFFF_FFFF_0000_0003 → `rsp_data`=old value, and `mcounteren_o`=0x3 afterward. S access to 0x306 → illegal.
- Hold `rsp_ready`=0 for 5 cycles while `mcycle` increments → `rsp_data` stays at the snapshot, `req_ready`=0, and a new `req_valid` is not accepted.
- Assert `rst` in RESP → `rsp_valid`=0 next cycle, both counteren registers read 0, and `req_ready`=1.
